// File: rtl/tm_pkg.sv
// Shared definitions for the Tsetlin-machine phase scheduler: state encoding
// and default phase lengths.
package tm_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_EVAL,
    S_FB,
    S_UPD,
    S_DONE
  } tm_state_e;

  localparam int TM_EVAL_CYC_DEF  = 4;
  localparam int TM_FB_CYC_DEF    = 8;
  localparam int TM_N_SAMPLES_DEF = 16;
  localparam int TM_EPOCH_W_DEF   = 8;

  function automatic int tm_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tm_phase_timer.sv
// Loadable down-counter with zero flag; times the EVAL and FEEDBACK phases.
module tm_phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                   cnt_d = load_val_i;
    else if (dec_i && cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/tm_phase_scheduler.sv
// Sequences WAIT/EVAL/FEEDBACK/UPDATE per sample over one epoch of samples,
// with abort, saturating epoch count and registered one-hot phase enables.
module tm_phase_scheduler
  import tm_pkg::*;
#(
  parameter int EVAL_CYC  = TM_EVAL_CYC_DEF,
  parameter int FB_CYC    = TM_FB_CYC_DEF,
  parameter int N_SAMPLES = TM_N_SAMPLES_DEF,
  parameter int EPOCH_W   = TM_EPOCH_W_DEF,
  localparam int SW       = $clog2(N_SAMPLES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               train,
  input  logic               sample_valid,
  output logic               sample_ready,
  output logic               eval_en,
  output logic               fb_en,
  output logic               upd_en,
  output logic               busy,
  output logic               done,
  output logic [SW-1:0]      sample_idx,
  output logic [EPOCH_W-1:0] epoch_cnt
);

  localparam int TW = $clog2(tm_max(EVAL_CYC, FB_CYC) + 1);

  tm_state_e          state_q, state_d;
  logic               train_q;
  logic [SW-1:0]      sidx_q, sidx_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic               ready_q, eval_q, fb_q, upd_q, busy_q, done_q;
  logic               tmr_load, tmr_dec, tmr_zero;
  logic [TW-1:0]      tmr_val;
  logic               last_smp, start_acc;

  assign last_smp  = (sidx_q == SW'(N_SAMPLES - 1));
  assign start_acc = (state_q == S_IDLE) && (state_d == S_WAIT);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start)                  state_d = S_WAIT;
      S_WAIT: if (sample_valid && ready_q) state_d = S_EVAL;
      S_EVAL: if (tmr_zero)               state_d = train_q ? S_FB : S_UPD;
      S_FB:   if (tmr_zero)               state_d = S_UPD;
      S_UPD:                              state_d = last_smp ? S_DONE : S_WAIT;
      S_DONE:                             state_d = S_IDLE;
      default:                            state_d = S_IDLE;
    endcase
    // Abort beats every other transition, including a start in IDLE.
    if (stop) state_d = S_IDLE;
  end

  // Reload on every phase entry so each phase always gets its full length.
  always_comb begin
    tmr_load = ((state_d == S_EVAL) && (state_q != S_EVAL)) ||
               ((state_d == S_FB)   && (state_q != S_FB));
    tmr_val  = (state_d == S_EVAL) ? TW'(EVAL_CYC - 1) : TW'(FB_CYC - 1);
    tmr_dec  = (state_q == S_EVAL) || (state_q == S_FB);
  end

  tm_phase_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    sidx_d  = sidx_q;
    epoch_d = epoch_q;
    if (start_acc) begin
      sidx_d = '0;
    end else if ((state_q == S_UPD) && (state_d != S_IDLE)) begin
      sidx_d = last_smp ? '0 : sidx_q + 1'b1;
      if (last_smp && epoch_q != '1) epoch_d = epoch_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      train_q <= 1'b0;
      sidx_q  <= '0;
      epoch_q <= '0;
      ready_q <= 1'b0;
      eval_q  <= 1'b0;
      fb_q    <= 1'b0;
      upd_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_acc) train_q <= train;
      sidx_q  <= sidx_d;
      epoch_q <= epoch_d;
      ready_q <= (state_d == S_WAIT);
      eval_q  <= (state_d == S_EVAL);
      fb_q    <= (state_d == S_FB);
      upd_q   <= (state_d == S_UPD);
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign sample_ready = ready_q;
  assign eval_en      = eval_q;
  assign fb_en        = fb_q;
  assign upd_en       = upd_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign sample_idx   = sidx_q;
  assign epoch_cnt    = epoch_q;

endmodule

// File: tb/tb_tm_phase_scheduler.sv
// Directed bench: two schedulers (EPOCH_W=8 and EPOCH_W=2) share stimulus.
module tb_tm_phase_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, stop = 1'b0, train = 1'b0, sample_valid = 1'b0;

  logic       rdy, ev, fb, up, bsy, dn;
  logic [3:0] sidx;
  logic [7:0] ep;
  logic       rdy2, ev2, fb2, up2, bsy2, dn2;
  logic [3:0] sidx2;
  logic [1:0] ep2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tm_phase_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .train(train),
    .sample_valid(sample_valid), .sample_ready(rdy), .eval_en(ev), .fb_en(fb),
    .upd_en(up), .busy(bsy), .done(dn), .sample_idx(sidx), .epoch_cnt(ep)
  );

  tm_phase_scheduler #(.EPOCH_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .train(train),
    .sample_valid(sample_valid), .sample_ready(rdy2), .eval_en(ev2), .fb_en(fb2),
    .upd_en(up2), .busy(bsy2), .done(dn2), .sample_idx(sidx2), .epoch_cnt(ep2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // One full run with sample_valid held high; counts per-cycle phase enables.
  task automatic run_pass(input bit tr, input int exp_ep, input int exp_ep2);
    int nr, ne, nf, nu, nd, u0, u1, cyc;
    nr = 0; ne = 0; nf = 0; nu = 0; nd = 0; u0 = -1; u1 = -1; cyc = 0;
    train = tr; sample_valid = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    while (nd == 0 && cyc < 400) begin
      if (rdy) nr++;
      if (ev)  ne++;
      if (fb)  nf++;
      if (up) begin
        nu++;
        if (u0 < 0) u0 = cyc; else if (u1 < 0) u1 = cyc;
      end
      if (dn) begin
        nd++;
        chk("busy_at_done", bsy, 1);
        chk("onehot_at_done", {ev, fb, up}, 0);
      end
      if (ev2 !== ev || fb2 !== fb || up2 !== up) chk("dut2_enables", {ev2, fb2, up2}, {ev, fb, up});
      tick();
      cyc++;
    end
    chk("done_seen", nd, 1);
    chk("ready_cycles", nr, 16);
    chk("eval_cycles", ne, 64);
    chk("fb_cycles", nf, tr ? 128 : 0);
    chk("upd_cycles", nu, 16);
    chk("sample_period", u1 - u0, tr ? 14 : 6);
    chk("busy_after_done", bsy, 0);
    chk("done_one_cycle", dn, 0);
    chk("sidx_after_done", sidx, 0);
    chk("epoch", ep, exp_ep);
    chk("epoch_w2", ep2, exp_ep2);
  endtask

  initial begin
    int guard;
    tick();
    chk("rst_busy", bsy, 0);
    chk("rst_enables", {rdy, ev, fb, up, dn}, 0);
    chk("rst_sidx", sidx, 0);
    chk("rst_epoch", ep, 0);
    rst_n = 1'b1;
    tick();

    // train mode, then inference mode
    run_pass(1'b1, 1, 1);
    run_pass(1'b0, 2, 2);

    // Feeder stalls in WAIT_S
    train = 1'b1; sample_valid = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("stall_ready", rdy, 1);
      chk("stall_no_eval", ev, 0);
      tick();
    end
    sample_valid = 1'b1;
    tick();
    chk("eval_after_valid", ev, 1);
    chk("ready_dropped", rdy, 0);

    // start while busy must be ignored
    guard = 0;
    while (!(sidx == 3 && ev) && guard < 200) begin tick(); guard++; end
    chk("reach_s3_eval", guard < 200, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_start_sidx", sidx, 3);
    chk("busy_start_busy", bsy, 1);

    // Abort during feedback of sample 5
    guard = 0;
    while (!(sidx == 5 && fb) && guard < 200) begin tick(); guard++; end
    chk("reach_s5_fb", guard < 200, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_busy", bsy, 0);
    chk("stop_enables", {rdy, ev, fb, up, dn}, 0);
    chk("stop_sidx", sidx, 5);
    chk("stop_epoch", ep, 2);
    tick();
    chk("stop_no_done", dn, 0);
    chk("stop_stays_idle", bsy, 0);

    // Asynchronous reset in the middle of EVAL
    train = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (!ev && guard < 20) begin tick(); guard++; end
    chk("reach_eval", ev, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_enables", {rdy, ev, fb, up, dn, bsy}, 0);
    chk("arst_epoch", ep, 0);
    chk("arst_sidx", sidx, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", {rdy, ev, fb, up, dn, bsy}, 0);
    tick();
    chk("post_rst_idle2", {rdy, ev, fb, up, dn, bsy}, 0);

    // Saturating epoch count on the narrow instance
    for (int r = 1; r <= 5; r++) run_pass(1'b0, r, (r > 3) ? 3 : r);

    // start and stop together in IDLE
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("start_stop_idle", {bsy, rdy}, 0);
    tick();
    chk("start_stop_idle2", {bsy, rdy, ev}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
